// File: rtl/checker_di_multi.sv
// Multi-sample data-integrity checker for the packet builder: samples payload bytes,
// computes the expected CRC-8, then verifies the built packet. Option: CHK_DI_ERR_CNT_EN.
module checker_di_multi #(
  parameter int          ADDR_W      = 14,
  parameter int          CNT_W       = 4,
  parameter int          NUM_SAMPLES = 2,
  parameter logic [7:0]  POLY        = 8'h07,
  parameter int          HDR_BYTES   = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         checker_en,
  input  logic                         pb_start,
  input  logic                         pb_irq_top,
  input  logic                         pb_crc_en,
  input  logic [7:0]                   pb_crc_val,
  input  logic [3:0]                   pb_data_sel,
  input  logic [CNT_W-1:0]             pb_byte_cnt,
  input  logic [ADDR_W-1:0]            pb_addr_in,
  input  logic [ADDR_W-1:0]            pb_addr_out,
  input  logic [NUM_SAMPLES*CNT_W-1:0] sample_idx,
  output logic [ADDR_W-1:0]            inmem_addr,
  input  logic [7:0]                   inmem_data,
  output logic [ADDR_W-1:0]            outmem_addr,
  input  logic [7:0]                   outmem_data,
  output logic [2:0]                   state_di,
  output logic                         busy,
  output logic                         done,
  output logic [NUM_SAMPLES-1:0]       di_err_vec,
  output logic                         di_err,
  output logic                         di_crc_err
`ifdef CHK_DI_ERR_CNT_EN
  ,
  output logic [15:0]                  pkt_cnt,
  output logic [15:0]                  di_err_cnt,
  output logic [15:0]                  crc_err_cnt
`endif
);

  localparam int CW = CNT_W + 2;

  typedef enum logic [2:0] {
    IDLE = 3'd0, SAMPLE_RD = 3'd1, CRC_CALC = 3'd2,
    WAIT_IRQ = 3'd3, OUT_RD = 3'd4, REPORT = 3'd5
  } state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic [CNT_W-1:0]  idx_q [NUM_SAMPLES];
  logic [7:0]        smp   [NUM_SAMPLES];
  logic [CNT_W-1:0]  byte_cnt_q;
  logic [3:0]        sel_q;
  logic [ADDR_W-1:0] addr_in_q, addr_out_q;
  logic              crc_en_q, irq_seen;
  logic [7:0]        crc_val_q, exp_crc, crc_acc, crc_fold;
  logic [NUM_SAMPLES-1:0] active;

  function automatic logic lane_used(input logic [3:0] m, input logic [CNT_W-1:0] i);
    case (m)
      4'd0:    return (i[1:0] == 2'b00);
      4'd1:    return !i[1];
      default: return 1'b1;
    endcase
  endfunction

  // Position of payload index i inside the packed output payload.
  function automatic logic [ADDR_W-1:0] lane_off(input logic [3:0] m, input logic [CNT_W-1:0] i);
    logic [ADDR_W-1:0] q;
    q = ADDR_W'(i >> 2);
    case (m)
      4'd0:    return q;
      4'd1:    return (q << 1) + ADDR_W'(i[1:0]);
      default: return ADDR_W'(i);
    endcase
  endfunction

  function automatic logic [ADDR_W-1:0] pcount(input logic [3:0] m, input logic [CNT_W-1:0] bc);
    logic [ADDR_W-1:0] q;
    q = ADDR_W'(bc >> 2);
    case (m)
      4'd0:    return q + ADDR_W'(1);
      4'd1:    return (q << 1) + (bc[1] ? ADDR_W'(2) : ADDR_W'(bc[0]) + ADDR_W'(1));
      default: return ADDR_W'(bc) + ADDR_W'(1);
    endcase
  endfunction

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int b = 0; b < 8; b++) r = r[7] ? ((r << 1) ^ POLY) : (r << 1);
    return r;
  endfunction

  assign state_di = state;
  assign busy     = (state != IDLE);

  always_comb begin
    for (int k = 0; k < NUM_SAMPLES; k++)
      active[k] = (idx_q[k] <= byte_cnt_q) && lane_used(sel_q, idx_q[k]);
    crc_fold = crc_acc;
    if (cnt != '0 && lane_used(sel_q, CNT_W'(cnt - 1'b1)))
      crc_fold = crc8(crc_acc, inmem_data);
  end

  always_comb begin
    inmem_addr  = '0;
    outmem_addr = '0;
    case (state)
      SAMPLE_RD:
        for (int k = 0; k < NUM_SAMPLES; k++)
          if (cnt == CW'(k)) inmem_addr = addr_in_q + ADDR_W'(idx_q[k]);
      CRC_CALC:
        if (cnt <= CW'(byte_cnt_q)) inmem_addr = addr_in_q + ADDR_W'(cnt);
      OUT_RD: begin
        for (int k = 0; k < NUM_SAMPLES; k++)
          if (cnt == CW'(k))
            outmem_addr = addr_out_q + ADDR_W'(HDR_BYTES) + lane_off(sel_q, idx_q[k]);
        if (cnt == CW'(NUM_SAMPLES))
          outmem_addr = addr_out_q + ADDR_W'(HDR_BYTES) + pcount(sel_q, byte_cnt_q);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE; cnt <= '0; byte_cnt_q <= '0; sel_q <= '0;
      addr_in_q <= '0; addr_out_q <= '0; crc_en_q <= 1'b0; crc_val_q <= '0;
      exp_crc <= '0; crc_acc <= '0; irq_seen <= 1'b0; done <= 1'b0;
      di_err_vec <= '0; di_err <= 1'b0; di_crc_err <= 1'b0;
      for (int k = 0; k < NUM_SAMPLES; k++) begin
        idx_q[k] <= '0;
        smp[k]   <= '0;
      end
`ifdef CHK_DI_ERR_CNT_EN
      pkt_cnt <= '0; di_err_cnt <= '0; crc_err_cnt <= '0;
`endif
    end else begin
      done <= 1'b0;
      if (state != IDLE && pb_irq_top) irq_seen <= 1'b1;
      case (state)
        IDLE:
          if (pb_start && checker_en) begin
            for (int k = 0; k < NUM_SAMPLES; k++) idx_q[k] <= sample_idx[k*CNT_W +: CNT_W];
            byte_cnt_q <= pb_byte_cnt; sel_q <= pb_data_sel;
            addr_in_q <= pb_addr_in; addr_out_q <= pb_addr_out;
            crc_en_q <= pb_crc_en; crc_val_q <= pb_crc_val;
            di_err_vec <= '0; di_err <= 1'b0; di_crc_err <= 1'b0;
            cnt <= '0;
            state <= SAMPLE_RD;
          end
        SAMPLE_RD: begin
          for (int k = 0; k < NUM_SAMPLES; k++)
            if (cnt == CW'(k + 1)) smp[k] <= inmem_data;
          if (cnt == CW'(NUM_SAMPLES)) begin
            cnt <= '0; crc_acc <= '0;
            if (crc_en_q) state <= CRC_CALC;
            else begin
              exp_crc <= crc_val_q;
              state   <= WAIT_IRQ;
            end
          end else cnt <= cnt + 1'b1;
        end
        CRC_CALC: begin
          crc_acc <= crc_fold;
          if (cnt == CW'(byte_cnt_q) + CW'(1)) begin
            exp_crc <= crc_fold; cnt <= '0; state <= WAIT_IRQ;
          end else cnt <= cnt + 1'b1;
        end
        WAIT_IRQ:
          if (irq_seen || pb_irq_top) begin
            cnt <= '0; state <= OUT_RD;
          end
        OUT_RD: begin
          for (int k = 0; k < NUM_SAMPLES; k++)
            if (cnt == CW'(k + 1) && active[k] && outmem_data != smp[k]) di_err_vec[k] <= 1'b1;
          if (cnt == CW'(NUM_SAMPLES + 1)) begin
            di_crc_err <= (outmem_data != exp_crc);
            di_err     <= |di_err_vec;
            done       <= 1'b1;
            state      <= REPORT;
          end else cnt <= cnt + 1'b1;
        end
        REPORT: begin
          irq_seen <= 1'b0;
          state    <= IDLE;
`ifdef CHK_DI_ERR_CNT_EN
          if (pkt_cnt != 16'hFFFF) pkt_cnt <= pkt_cnt + 16'd1;
          if (di_err && di_err_cnt != 16'hFFFF) di_err_cnt <= di_err_cnt + 16'd1;
          if (di_crc_err && crc_err_cnt != 16'hFFFF) crc_err_cnt <= crc_err_cnt + 16'd1;
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_checker_di_multi.sv
// Bench for checker_di_multi: directed and random packets against a packet-level reference model.
module tb_checker_di_multi;
  localparam int ADDR_W = 14, CNT_W = 4, NS = 2, HDR = 2;
  localparam int AM = 1 << ADDR_W;
  localparam logic [7:0] POLY = 8'h07;

  logic clk = 1'b0, reset = 1'b1;
  logic checker_en = 1'b0, pb_start = 1'b0, pb_irq_top = 1'b0, pb_crc_en = 1'b0;
  logic [7:0] pb_crc_val = '0;
  logic [3:0] pb_data_sel = '0;
  logic [CNT_W-1:0] pb_byte_cnt = '0;
  logic [ADDR_W-1:0] pb_addr_in = '0, pb_addr_out = '0;
  logic [NS*CNT_W-1:0] sample_idx = '0;
  logic [ADDR_W-1:0] inmem_addr, outmem_addr;
  logic [7:0] inmem_data = '0, outmem_data = '0;
  logic [2:0] state_di;
  logic busy, done, di_err, di_crc_err;
  logic [NS-1:0] di_err_vec;

  logic [7:0] imem [0:AM-1];
  logic [7:0] omem [0:AM-1];
  int total = 0, bad = 0;

  checker_di_multi dut (
    .clk(clk), .reset(reset), .checker_en(checker_en), .pb_start(pb_start),
    .pb_irq_top(pb_irq_top), .pb_crc_en(pb_crc_en), .pb_crc_val(pb_crc_val),
    .pb_data_sel(pb_data_sel), .pb_byte_cnt(pb_byte_cnt), .pb_addr_in(pb_addr_in),
    .pb_addr_out(pb_addr_out), .sample_idx(sample_idx), .inmem_addr(inmem_addr),
    .inmem_data(inmem_data), .outmem_addr(outmem_addr), .outmem_data(outmem_data),
    .state_di(state_di), .busy(busy), .done(done), .di_err_vec(di_err_vec),
    .di_err(di_err), .di_crc_err(di_crc_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    inmem_data  <= imem[inmem_addr];
    outmem_data <= omem[outmem_addr];
  end

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic bit lane_used(input int mode, input int i);
    if (mode == 0) return (i % 4) == 0;
    if (mode == 1) return (i % 4) < 2;
    return 1'b1;
  endfunction

  task automatic check_idle_clear(input string tag);
    chk({tag, "_state"}, 32'(state_di), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_flags"}, 32'({di_err_vec, di_err, di_crc_err}), 0);
    chk({tag, "_addrs"}, 32'({inmem_addr, outmem_addr}), 0);
  endtask

  // One packet: build memories, run the DUT, compare with the packet-level model.
  task automatic run_pkt(input int mode, input int bc, input int s0, input int s1,
                         input bit crc_en, input logic [7:0] crc_val, input int ain, input int aout,
                         input int corrupt_j, input bit corrupt_crc, input bit early_irq,
                         input int wait_d, input bit irq_at_start, input bit start_busy,
                         input bit rst_in_out, input bit fixed_data);
    int used_q[$];
    int sidx[NS];
    int pos[NS];
    bit act[NS];
    logic [7:0] crc, d, exp_crc;
    logic [NS-1:0] exp_vec;
    logic [ADDR_W-1:0] iaddr[$], oaddr[$];
    int nsr, ncrc, nwait, nout, crc_loc;
    bit fired, got;
    logic [NS-1:0] r_vec;
    logic r_err, r_crc;
    bit fb;
    sidx[0] = s0; sidx[1] = s1;
    for (int i = 0; i <= bc; i++) imem[(ain + i) % AM] = fixed_data ? 8'(11 + i) : 8'($urandom);
    for (int i = 0; i <= bc; i++) if (lane_used(mode, i)) used_q.push_back(i);
    crc = 8'h00;
    foreach (used_q[j]) begin
      d = imem[(ain + used_q[j]) % AM];
      for (int b = 7; b >= 0; b--) begin
        fb = crc[7] ^ d[b];
        crc = {crc[6:0], 1'b0};
        if (fb) crc = crc ^ POLY;
      end
    end
    exp_crc = crc_en ? crc : crc_val;
    foreach (used_q[j]) omem[(aout + HDR + j) % AM] = imem[(ain + used_q[j]) % AM];
    crc_loc = (aout + HDR + used_q.size()) % AM;
    omem[crc_loc] = corrupt_crc ? (exp_crc ^ 8'h01) : exp_crc;
    if (corrupt_j >= 0) omem[(aout + HDR + corrupt_j) % AM] ^= 8'h5A;
    for (int k = 0; k < NS; k++) begin
      pos[k] = -1;
      foreach (used_q[j]) if (used_q[j] == sidx[k]) pos[k] = j;
      act[k] = (pos[k] >= 0);
      exp_vec[k] = act[k] && (omem[(aout + HDR + pos[k]) % AM] != imem[(ain + sidx[k]) % AM]);
    end

    @(negedge clk);
    checker_en = 1'b1; pb_start = 1'b1; pb_irq_top = irq_at_start;
    pb_data_sel = 4'(mode); pb_byte_cnt = CNT_W'(bc); pb_crc_en = crc_en; pb_crc_val = crc_val;
    pb_addr_in = ADDR_W'(ain); pb_addr_out = ADDR_W'(aout);
    sample_idx = {CNT_W'(s1), CNT_W'(s0)};
    @(negedge clk);
    pb_start = 1'b0; pb_irq_top = 1'b0;
    pb_data_sel = 4'($urandom); pb_byte_cnt = CNT_W'($urandom); pb_crc_en = 1'($urandom);
    pb_crc_val = 8'($urandom); pb_addr_in = ADDR_W'($urandom); pb_addr_out = ADDR_W'($urandom);
    sample_idx = (NS*CNT_W)'($urandom);

    nsr = 0; ncrc = 0; nwait = 0; nout = 0; fired = 0; got = 0;
    r_vec = '0; r_err = 0; r_crc = 0;
    for (int cyc = 0; cyc < 200 && !got; cyc++) begin
      pb_irq_top = 1'b0; pb_start = 1'b0;
      case (state_di)
        3'd1: begin iaddr.push_back(inmem_addr); nsr++; end
        3'd2: ncrc++;
        3'd3: nwait++;
        3'd4: begin oaddr.push_back(outmem_addr); nout++; end
        default: ;
      endcase
      if (start_busy && state_di == 3'd1 && nsr == 1) pb_start = 1'b1;
      if (!fired && early_irq && state_di == (crc_en ? 3'd2 : 3'd1)) begin pb_irq_top = 1'b1; fired = 1; end
      if (!fired && !early_irq && state_di == 3'd3 && nwait == wait_d) begin pb_irq_top = 1'b1; fired = 1; end
      if (rst_in_out && state_di == 3'd4) begin
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_idle_clear("rst_outrd");
        return;
      end
      if (done) begin got = 1; r_vec = di_err_vec; r_err = di_err; r_crc = di_crc_err; end
      @(negedge clk);
    end
    chk("done_seen", 32'(got), 1);
    chk("sample_rd_cycles", nsr, NS + 1);
    chk("crc_calc_cycles", ncrc, crc_en ? bc + 2 : 0);
    chk("wait_irq_cycles", nwait, early_irq ? 1 : wait_d);
    chk("out_rd_cycles", nout, NS + 2);
    for (int k = 0; k < NS && k < iaddr.size(); k++)
      chk($sformatf("in_addr%0d", k), 32'(iaddr[k]), (ain + sidx[k]) % AM);
    for (int k = 0; k < NS && k < oaddr.size(); k++)
      if (act[k]) chk($sformatf("out_addr%0d", k), 32'(oaddr[k]), (aout + HDR + pos[k]) % AM);
    if (oaddr.size() > NS) chk("crc_addr", 32'(oaddr[NS]), crc_loc);
    chk("err_vec", 32'(r_vec), 32'(exp_vec));
    chk("di_err", 32'(r_err), 32'(|exp_vec));
    chk("crc_err", 32'(r_crc), 32'(corrupt_crc));
    chk("post_state", 32'(state_di), 0);
    chk("post_done", 32'(done), 0);
    chk("post_hold", 32'({di_err_vec, di_err, di_crc_err}), 32'({exp_vec, |exp_vec, corrupt_crc}));
  endtask

  initial begin
    logic [NS+1:0] held;
    repeat (3) @(negedge clk);
    check_idle_clear("reset");
    reset = 1'b0;

    // mode 2, samples 1 and 4, clean copy
    run_pkt(2, 5, 1, 4, 1, 8'h00, 100, 200, -1, 0, 0, 2, 0, 0, 0, 1);
    // mode 1, sample 2 unused lane, payload offset 1 corrupted
    run_pkt(1, 7, 1, 2, 1, 8'h00, 300, 400, 1, 0, 0, 1, 0, 0, 0, 0);
    held = {di_err_vec, di_err, di_crc_err};
    // start ignored while checker disabled
    @(negedge clk); checker_en = 1'b0; pb_start = 1'b1;
    @(negedge clk); pb_start = 1'b0;
    chk("disabled_state", 32'(state_di), 0);
    chk("disabled_hold", 32'({di_err_vec, di_err, di_crc_err}), 32'(held));
    // predefined CRC, wrong CRC byte
    run_pkt(0, 8, 0, 4, 0, 8'hA5, 500, 600, -1, 1, 0, 3, 0, 0, 0, 0);
    // irq during CRC_CALC, restart attempt while busy, address wrap
    run_pkt(2, 9, 3, 9, 1, 8'h00, AM - 4, AM - 6, -1, 0, 1, 1, 0, 1, 0, 0);
    // irq together with start in IDLE is dropped
    run_pkt(3, 6, 6, 0, 1, 8'h00, 700, 800, 3, 0, 0, 4, 1, 0, 0, 0);
    // reset during OUT_RD, then a clean packet
    run_pkt(2, 5, 2, 3, 1, 8'h00, 900, 1000, -1, 0, 0, 1, 0, 0, 1, 0);
    run_pkt(1, 12, 5, 12, 1, 8'h00, 1100, 1200, 4, 0, 0, 2, 0, 0, 0, 0);

    for (int n = 0; n < 16; n++) begin
      int m, b, c;
      m = $urandom_range(0, 5);
      b = $urandom_range(0, 15);
      c = $urandom_range(0, 3) == 0 ? $urandom_range(0, 15) : -1;
      run_pkt(m, b, $urandom_range(0, 15), $urandom_range(0, 15), 1'($urandom),
              8'($urandom), $urandom_range(0, AM - 1), $urandom_range(0, AM - 1),
              c, 1'($urandom_range(0, 3) == 0), 1'($urandom), $urandom_range(1, 4),
              1'($urandom), 1'($urandom), 0, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
